// File: rtl/secret_file_loader.sv
// ---------------------------------------------------------------------------
// secret_file_loader
//
// Host-side writer for the 7-bit word-shift display controller. Bytes from the
// host are mapped to display words and stored locally. Once a message is
// committed (buffer full, or flush with data), the words are bit-banged to the
// controller pins one per two cycles. The loader then drives 7'h7F playback
// strobes while the next message collects.
//
// Optional build macro:
//   SECRET_FILE_ASCII_FOLD_EN - fold ASCII 0x60..0x7E to uppercase before
//                               mapping; 0x7F maps to blank.
//
// Ports:
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   in_valid  in   1  host byte valid
//   in_ready  out  1  loader accepts a byte this cycle
//   in_data   in   8  bit7=1: raw column word [5:0]; bit7=0: ASCII character
//   flush     in   1  commit a partial message (padded with blanks)
//   play_en   in   1  enable playback strobes while in PLAY
//   out_clk   out  1  controller pin clock (controller samples on rising edge)
//   out_din   out  7  controller 7-bit data pins
//   busy      out  1  high while words are being sent
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; pins quiet (0), collecting the first message
// SEND  | shifting WORD_COUNT words out, phase A (clk low) / B (clk high)
// PLAY  | data pins at 7'h7F, pin clock toggles when play_en; collecting
// ---------------------------------------------------------------------------
module secret_file_loader #(
    parameter int WORD_COUNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       flush,
    input  logic       play_en,
    output logic       out_clk,
    output logic [6:0] out_din,
    output logic       busy
);

    localparam int IW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int WW = $clog2(WORD_COUNT + 1);
    localparam logic [6:0] BLANK  = 7'h40;
    localparam logic [6:0] STROBE = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WW-1:0]  widx_q, widx_d;
    logic [IW-1:0]  sidx_q, sidx_d;
    logic           phase_q, phase_d;
    logic           out_clk_d;
    logic [6:0]     out_din_d;
    logic           in_ready_d;
    logic           busy_d;
    logic [6:0]     slot_q [WORD_COUNT];

    logic           accept;
    logic           commit;
    logic [6:0]     mapped;
    logic [6:0]     entry_word;
    logic [6:0]     next_word;
    logic [WW-1:0]  next_slot;

    // Blank (7'h40) is the fallback so that no data word can ever equal the
    // 7'h7F playback strobe: '_' would otherwise map to {1, 6'h3F}.
    function automatic logic [6:0] map_byte(input logic [7:0] b);
        logic [6:0] c;
        logic [6:0] sub;
        logic [6:0] w;
        c   = b[6:0];
        w   = BLANK;
`ifdef SECRET_FILE_ASCII_FOLD_EN
        if (c >= 7'h60 && c <= 7'h7E) begin
            c = c - 7'h20;
        end
`endif
        sub = c - 7'h20;
        if (b[7]) begin
            w = {1'b0, b[5:0]};
        end else if (c >= 7'h20 && c <= 7'h5E) begin
            w = {1'b1, sub[5:0]};
        end
        return w;
    endfunction

    assign accept = in_valid && in_ready;
    assign mapped = map_byte(in_data);

    // widx==WORD_COUNT only occurs with in_ready low, so no byte can be lost.
    assign commit = (widx_q == WW'(WORD_COUNT)) ||
                    (flush && (accept || (widx_q != '0)));

    // Slot 0 bypasses the buffer when it is being written on the commit edge
    // itself (flush together with the first byte).
    assign entry_word = (widx_q == '0) ? mapped : slot_q[0];

    assign next_slot = WW'(sidx_q) + WW'(1);
    assign next_word = (next_slot < widx_q) ? slot_q[next_slot[IW-1:0]] : BLANK;

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        sidx_d    = sidx_q;
        phase_d   = phase_q;
        out_clk_d = 1'b0;
        out_din_d = out_din;

        if (accept) begin
            widx_d = widx_q + WW'(1);
        end

        case (state_q)
            S_IDLE: begin
                out_din_d = 7'h00;
                if (commit) begin
                    state_d   = S_SEND;
                    sidx_d    = '0;
                    phase_d   = 1'b0;
                    out_din_d = entry_word;
                end
            end
            S_SEND: begin
                if (!phase_q) begin
                    phase_d   = 1'b1;
                    out_clk_d = 1'b1;
                end else if (sidx_q == IW'(WORD_COUNT - 1)) begin
                    // Clock drops on this edge, so the strobe value is
                    // presented only while the pin clock is low.
                    state_d   = S_PLAY;
                    widx_d    = '0;
                    phase_d   = 1'b0;
                    out_din_d = STROBE;
                end else begin
                    sidx_d    = sidx_q + IW'(1);
                    phase_d   = 1'b0;
                    out_din_d = next_word;
                end
            end
            S_PLAY: begin
                out_din_d = STROBE;
                if (commit) begin
                    // Phase A drives the clock low, so any high phase in
                    // progress completes its full cycle first.
                    state_d   = S_SEND;
                    sidx_d    = '0;
                    phase_d   = 1'b0;
                    out_din_d = entry_word;
                end else begin
                    out_clk_d = play_en && !out_clk;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d != S_SEND) && (widx_d < WW'(WORD_COUNT));
        busy_d     = (state_d == S_SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            widx_q   <= '0;
            sidx_q   <= '0;
            phase_q  <= 1'b0;
            out_clk  <= 1'b0;
            out_din  <= 7'h00;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            sidx_q   <= sidx_d;
            phase_q  <= phase_d;
            out_clk  <= out_clk_d;
            out_din  <= out_din_d;
            in_ready <= in_ready_d;
            busy     <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
                slot_q[i] <= BLANK;
            end
        end else if (accept) begin
            slot_q[widx_q[IW-1:0]] <= mapped;
        end
    end

endmodule

// File: tb/tb_secret_file_loader.sv
module tb_secret_file_loader;

    localparam int WC = 20;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       flush;
    logic       play_en;
    logic       out_clk;
    logic [6:0] out_din;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] exp_words [WC];

    typedef struct {
        logic [7:0] data;
        logic [6:0] word;
    } vec_t;

    vec_t vecs [12];

    secret_file_loader #(.WORD_COUNT(WC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .play_en  (play_en),
        .out_clk  (out_clk),
        .out_din  (out_din),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one byte; returns on the negedge after the transfer edge.
    task automatic push(input logic [7:0] b, input logic fl);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        flush    = fl;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Follows one complete SEND against exp_words, ending on the first PLAY cycle.
    task automatic capture_send(input string tag);
        int n;
        n = 0;
        while (!busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        if (!busy) return;
        check({tag, "_ready_in_send"}, {31'd0, in_ready}, 32'd0);
        for (int w = 0; w < WC; w++) begin
            check($sformatf("%s_w%0d_A", tag, w), {23'd0, busy, out_clk, out_din},
                  {23'd0, 1'b1, 1'b0, exp_words[w]});
            @(negedge clk);
            check($sformatf("%s_w%0d_B", tag, w), {23'd0, busy, out_clk, out_din},
                  {23'd0, 1'b1, 1'b1, exp_words[w]});
            @(negedge clk);
        end
        check({tag, "_play_entry"}, {23'd0, busy, out_clk, out_din},
              {23'd0, 1'b0, 1'b0, 7'h7F});
    endtask

    initial begin
        // 'A'=0x41 -> {1, 0x21} = 0x61, '^'=0x5E -> 0x7E, ' ' -> 0x40
        vecs[0]  = '{8'h41, 7'h61};
        vecs[1]  = '{8'h48, 7'h68};
        vecs[2]  = '{8'h20, 7'h40};
        vecs[3]  = '{8'h5E, 7'h7E};
        vecs[4]  = '{8'h5F, 7'h40};
        vecs[5]  = '{8'h85, 7'h05};
        vecs[6]  = '{8'hBF, 7'h3F};
        vecs[7]  = '{8'h1F, 7'h40};
        vecs[8]  = '{8'h30, 7'h50};
        vecs[9]  = '{8'h7F, 7'h40};
`ifdef SECRET_FILE_ASCII_FOLD_EN
        // 'z' folds to 'Z'=0x5A -> {1, 0x3A}; '`' folds to '@'=0x40 -> {1, 0x20}
        vecs[10] = '{8'h7A, 7'h7A};
        vecs[11] = '{8'h60, 7'h60};
`else
        vecs[10] = '{8'h7A, 7'h40};
        vecs[11] = '{8'h60, 7'h40};
`endif

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        flush    = 1'b0;
        play_en  = 1'b1;
        #2;
        check("reset_outputs", {22'd0, out_clk, out_din, in_ready, busy}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_outputs", {22'd0, out_clk, out_din, in_ready, busy},
              {22'd0, 1'b0, 7'h00, 1'b1, 1'b0});

        // Full message of 'A'
        for (int i = 0; i < WC; i++) exp_words[i] = 7'h61;
        for (int i = 0; i < WC; i++) push(8'h41, 1'b0);
        capture_send("msgA");

        for (int i = 0; i < 6; i++) begin
            check($sformatf("play_toggle_%0d", i), {24'd0, out_clk, out_din},
                  {24'd0, 1'(i % 2), 7'h7F});
            @(negedge clk);
        end

        play_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("play_hold_%0d", i), {24'd0, out_clk, out_din}, {24'd0, 1'b0, 7'h7F});
            @(negedge clk);
        end
        play_en = 1'b1;

        // Flush on an empty buffer is ignored
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("empty_flush_%0d", i), {31'd0, busy}, 32'd0);
            @(negedge clk);
        end

        // 'H','I' then flush: stale 'A' words must not reappear
        exp_words[0] = 7'h68;
        exp_words[1] = 7'h69;
        for (int i = 2; i < WC; i++) exp_words[i] = 7'h40;
        push(8'h48, 1'b0);
        push(8'h49, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        capture_send("msgHI");

        // Full message 'A'..'T' collected in PLAY
        for (int i = 0; i < WC; i++) exp_words[i] = 7'h61 + 7'(i);
        for (int i = 0; i < WC; i++) push(8'h41 + 8'(i), 1'b0);
        capture_send("msgAT");

        // Single-byte messages, flushed in the same cycle as the byte
        for (int v = 0; v < 12; v++) begin
            exp_words[0] = vecs[v].word;
            for (int i = 1; i < WC; i++) exp_words[i] = 7'h40;
            push(vecs[v].data, 1'b1);
            capture_send($sformatf("vec%0d", v));
        end

        // Reset during word 7 of a SEND
        for (int i = 0; i < WC; i++) push(8'h41, 1'b0);
        begin
            int n;
            n = 0;
            while (!busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rst_busy_start", {31'd0, busy}, 32'd1);
        end
        repeat (14) @(negedge clk);
        check("rst_word7", {24'd0, out_clk, out_din}, {24'd0, 1'b0, 7'h61});
        rst_n = 1'b0;
        #1;
        check("rst_mid_send", {22'd0, out_clk, out_din, in_ready, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold_%0d", i), {24'd0, out_clk, out_din}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {22'd0, out_clk, out_din, in_ready, busy},
              {22'd0, 1'b0, 7'h00, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
